// File: rtl/ysyx_22051086_trap_ctrl.sv
// Machine-mode trap/mret sequencer: stalls the pipeline, writes mepc/mcause/mstatus
// one CSR per cycle, then redirects the PC to mtvec (trap) or mepc (mret).
module ysyx_22051086_trap_ctrl #(
  parameter logic [63:0] ECALL_CAUSE = 64'd11,
  parameter logic [63:0] TIMER_CAUSE = 64'h8000_0000_0000_0007
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] pc,
  input  logic        ecall,
  input  logic        mret,
  input  logic        timer_irq,
  output logic [11:0] csr_rnum,
  input  logic [63:0] csr_rdata,
  output logic        csr_wen,
  output logic [11:0] csr_wnum,
  output logic [63:0] csr_wdata,
  output logic [63:0] csr_wmask,
  output logic        stall,
  output logic        redirect_valid,
  output logic [63:0] redirect_pc
);

  typedef enum logic [2:0] {
    StIdle, StTEpc, StTCause, StTStat, StTVec, StMStat, StMVec
  } state_e;

  state_e      state_q, state_d;
  logic [63:0] pc_q, cause_q, mst_q;
  logic        in_idle, irq_take, trap_take, mret_take;

  // csr_rdata holds mstatus while idle, so MIE gating of the timer is valid only here.
  assign in_idle   = (state_q == StIdle);
  assign irq_take  = in_idle & timer_irq & csr_rdata[3];
  assign trap_take = in_idle & (ecall | irq_take);
  assign mret_take = in_idle & mret & ~(ecall | irq_take);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      pc_q    <= 64'h0;
      cause_q <= 64'h0;
      mst_q   <= 64'h0;
    end else begin
      state_q <= state_d;
      if (trap_take) begin
        pc_q    <= pc;
        cause_q <= irq_take ? TIMER_CAUSE : ECALL_CAUSE;
        mst_q   <= csr_rdata;
      end else if (mret_take) begin
        mst_q <= csr_rdata;
      end
    end
  end

  always_comb begin
    state_d        = state_q;
    csr_rnum       = 12'h300;
    csr_wen        = 1'b0;
    csr_wnum       = 12'h000;
    csr_wdata      = 64'h0;
    csr_wmask      = 64'h0;
    stall          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 64'h0;
    unique case (state_q)
      StIdle: begin
        if (trap_take) begin
          state_d = StTEpc;
          stall   = 1'b1;
        end else if (mret_take) begin
          state_d = StMStat;
          stall   = 1'b1;
        end
      end
      StTEpc: begin
        state_d   = StTCause;
        stall     = 1'b1;
        csr_wen   = 1'b1;
        csr_wnum  = 12'h341;
        csr_wdata = pc_q;
      end
      StTCause: begin
        state_d   = StTStat;
        stall     = 1'b1;
        csr_wen   = 1'b1;
        csr_wnum  = 12'h342;
        csr_wdata = cause_q;
      end
      StTStat: begin
        state_d          = StTVec;
        stall            = 1'b1;
        csr_wen          = 1'b1;
        csr_wnum         = 12'h300;
        csr_wdata        = mst_q;
        csr_wdata[7]     = mst_q[3];
        csr_wdata[3]     = 1'b0;
        csr_wdata[12:11] = 2'b11;
      end
      StTVec: begin
        state_d        = StIdle;
        csr_rnum       = 12'h305;
        redirect_valid = 1'b1;
        redirect_pc    = {csr_rdata[63:2], 2'b00};
      end
      StMStat: begin
        state_d          = StMVec;
        stall            = 1'b1;
        csr_wen          = 1'b1;
        csr_wnum         = 12'h300;
        csr_wdata        = mst_q;
        csr_wdata[3]     = mst_q[7];
        csr_wdata[7]     = 1'b1;
        csr_wdata[12:11] = 2'b11;
      end
      StMVec: begin
        state_d        = StIdle;
        csr_rnum       = 12'h341;
        redirect_valid = 1'b1;
        redirect_pc    = csr_rdata;
      end
      default: state_d = StIdle;
    endcase
  end

endmodule

// File: tb/tb_ysyx_22051086_trap_ctrl.sv
// Directed bench for the trap/mret sequencer: per-cycle checks of stall, CSR writes
// and redirect against hand-computed values.
module tb_ysyx_22051086_trap_ctrl;

  logic        clk, rst;
  logic [63:0] pc;
  logic        ecall, mret, timer_irq;
  logic [11:0] csr_rnum;
  logic [63:0] csr_rdata;
  logic        csr_wen;
  logic [11:0] csr_wnum;
  logic [63:0] csr_wdata, csr_wmask;
  logic        stall, redirect_valid;
  logic [63:0] redirect_pc;

  logic [63:0] mstatus_v, mtvec_v, mepc_v;
  int          total = 0;
  int          bad   = 0;

  ysyx_22051086_trap_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .pc             (pc),
    .ecall          (ecall),
    .mret           (mret),
    .timer_irq      (timer_irq),
    .csr_rnum       (csr_rnum),
    .csr_rdata      (csr_rdata),
    .csr_wen        (csr_wen),
    .csr_wnum       (csr_wnum),
    .csr_wdata      (csr_wdata),
    .csr_wmask      (csr_wmask),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
  );

  // Static CSR file: values are set directly by the stimulus.
  assign csr_rdata = (csr_rnum == 12'h300) ? mstatus_v :
                     (csr_rnum == 12'h305) ? mtvec_v   :
                     (csr_rnum == 12'h341) ? mepc_v    : 64'h0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic cyc(input string tag, input logic es, input logic ew, input logic [11:0] wn,
                     input logic [63:0] wd, input logic er, input logic [63:0] rp);
    check({tag, " stall"}, 64'(stall), 64'(es));
    check({tag, " wen"}, 64'(csr_wen), 64'(ew));
    if (ew) begin
      check({tag, " wnum"}, 64'(csr_wnum), 64'(wn));
      check({tag, " wdata"}, csr_wdata, wd);
      check({tag, " wmask"}, csr_wmask, 64'h0);
    end
    check({tag, " rv"}, 64'(redirect_valid), 64'(er));
    check({tag, " rpc"}, redirect_pc, rp);
  endtask

  initial begin
    rst = 1'b1; pc = 64'h0; ecall = 1'b0; mret = 1'b0; timer_irq = 1'b0;
    mstatus_v = 64'h0; mtvec_v = 64'h0; mepc_v = 64'h0;
    @(negedge clk); @(negedge clk); #1;
    cyc("reset", 1'b0, 1'b0, 12'h0, 64'h0, 1'b0, 64'h0);
    check("reset rnum", 64'(csr_rnum), 64'h300);
    rst = 1'b0;

    // ecall trap
    @(negedge clk);
    mstatus_v = 64'ha00001800; mtvec_v = 64'h8000_0100; pc = 64'h8000_0040; ecall = 1'b1;
    #1; check("ec c0 rnum", 64'(csr_rnum), 64'h300);
    cyc("ec c0", 1'b1, 1'b0, 12'h0, 64'h0, 1'b0, 64'h0);
    @(negedge clk); ecall = 1'b0; pc = 64'h0; #1;
    cyc("ec c1", 1'b1, 1'b1, 12'h341, 64'h8000_0040, 1'b0, 64'h0);
    @(negedge clk); #1;
    cyc("ec c2", 1'b1, 1'b1, 12'h342, 64'd11, 1'b0, 64'h0);
    @(negedge clk); #1;
    cyc("ec c3", 1'b1, 1'b1, 12'h300, 64'ha00001800, 1'b0, 64'h0);
    @(negedge clk); #1;
    check("ec c4 rnum", 64'(csr_rnum), 64'h305);
    cyc("ec c4", 1'b0, 1'b0, 12'h0, 64'h0, 1'b1, 64'h8000_0100);
    @(negedge clk); #1;
    cyc("ec c5", 1'b0, 1'b0, 12'h0, 64'h0, 1'b0, 64'h0);

    // timer beats ecall; unaligned mtvec
    @(negedge clk);
    mstatus_v = 64'ha00001808; mtvec_v = 64'h8000_0103; pc = 64'h8000_0080;
    ecall = 1'b1; timer_irq = 1'b1;
    #1; cyc("ti c0", 1'b1, 1'b0, 12'h0, 64'h0, 1'b0, 64'h0);
    @(negedge clk); ecall = 1'b0; timer_irq = 1'b0; #1;
    cyc("ti c1", 1'b1, 1'b1, 12'h341, 64'h8000_0080, 1'b0, 64'h0);
    @(negedge clk); #1;
    cyc("ti c2", 1'b1, 1'b1, 12'h342, 64'h8000_0000_0000_0007, 1'b0, 64'h0);
    @(negedge clk); #1;
    cyc("ti c3", 1'b1, 1'b1, 12'h300, 64'ha00001880, 1'b0, 64'h0);
    @(negedge clk); #1;
    cyc("ti c4", 1'b0, 1'b0, 12'h0, 64'h0, 1'b1, 64'h8000_0100);
    @(negedge clk); #1;
    cyc("ti c5", 1'b0, 1'b0, 12'h0, 64'h0, 1'b0, 64'h0);

    // masked timer interrupt is ignored
    @(negedge clk); mstatus_v = 64'ha00001800; timer_irq = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1; cyc("masked", 1'b0, 1'b0, 12'h0, 64'h0, 1'b0, 64'h0);
      @(negedge clk);
    end
    timer_irq = 1'b0;

    // mret
    mstatus_v = 64'ha00001880; mepc_v = 64'h8000_0044; mret = 1'b1;
    #1; cyc("mr c0", 1'b1, 1'b0, 12'h0, 64'h0, 1'b0, 64'h0);
    @(negedge clk); mret = 1'b0; #1;
    cyc("mr c1", 1'b1, 1'b1, 12'h300, 64'ha00001888, 1'b0, 64'h0);
    @(negedge clk); #1;
    check("mr c2 rnum", 64'(csr_rnum), 64'h341);
    cyc("mr c2", 1'b0, 1'b0, 12'h0, 64'h0, 1'b1, 64'h8000_0044);
    @(negedge clk); #1;
    cyc("mr c3", 1'b0, 1'b0, 12'h0, 64'h0, 1'b0, 64'h0);

    // reset pulse during T_CAUSE abandons the trap
    @(negedge clk);
    mstatus_v = 64'ha00001800; mtvec_v = 64'h8000_0100; pc = 64'h8000_00c0; ecall = 1'b1;
    #1; cyc("rs c0", 1'b1, 1'b0, 12'h0, 64'h0, 1'b0, 64'h0);
    @(negedge clk); ecall = 1'b0; #1;
    cyc("rs c1", 1'b1, 1'b1, 12'h341, 64'h8000_00c0, 1'b0, 64'h0);
    @(negedge clk); #1;
    cyc("rs c2", 1'b1, 1'b1, 12'h342, 64'd11, 1'b0, 64'h0);
    #1 rst = 1'b1;
    #1 cyc("rs async", 1'b0, 1'b0, 12'h0, 64'h0, 1'b0, 64'h0);
    #1 rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); #1;
      cyc("rs after", 1'b0, 1'b0, 12'h0, 64'h0, 1'b0, 64'h0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
